// File: rtl/fixed_point_sub.sv
`default_nettype none
// ============================================================================
//  fixed_point_sub
//  Two-stage signed fixed-point subtractor (A - B) with valid/ready flow
//  control, selectable saturate/wrap and a sticky overflow flag.
//  Revision: 1.0
// ============================================================================
module fixed_point_sub #(
   parameter int WIDTH     = 8,
   parameter int FRAC_BITS = 3,
   parameter int SATURATE  = 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] VALUE_A_IN,
   input  logic [WIDTH-1:0] VALUE_B_IN,
   input  logic             VALID_IN,
   output logic             READY_OUT,
   output logic [WIDTH-1:0] VALUE_OUT,
   output logic             VALID_OUT,
   input  logic             READY_IN,
   output logic             OVERFLOW,
   output logic             OVERFLOW_STICKY,
   input  logic             CLEAR_STICKY
);

   localparam logic [WIDTH-1:0] c_max_pos = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] c_max_neg = {1'b1, {(WIDTH-1){1'b0}}};

   if (!(FRAC_BITS > 0 && FRAC_BITS < WIDTH)) begin : g_frac_bits_check
      $error("fixed_point_sub: FRAC_BITS must satisfy 0 < FRAC_BITS < WIDTH");
   end

   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH:0]   s1_diff_q,  s1_diff_d;
   logic             s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] value_q,    value_d;
   logic             ovf_q,      ovf_d;
   logic             sticky_q,   sticky_d;

   logic             w_s2_load;
   logic             w_in_xfer;
   logic             w_out_xfer;

   // READY_OUT stays a single AND/OR level deep on READY_IN.
   assign w_s2_load  = s1_valid_q && (!s2_valid_q || READY_IN);
   assign READY_OUT  = !s1_valid_q || w_s2_load;
   assign w_in_xfer  = VALID_IN && READY_OUT;
   assign w_out_xfer = s2_valid_q && READY_IN;

   always_comb begin
      logic w_ovf;
      s1_valid_d = s1_valid_q;
      s1_diff_d  = s1_diff_q;
      s2_valid_d = s2_valid_q;
      value_d    = value_q;
      ovf_d      = ovf_q;
      sticky_d   = sticky_q;

      // One extra bit makes the difference exact; overflow is judged in stage 2.
      if (w_in_xfer) begin
         s1_valid_d = 1'b1;
         s1_diff_d  = {VALUE_A_IN[WIDTH-1], VALUE_A_IN} - {VALUE_B_IN[WIDTH-1], VALUE_B_IN};
      end else if (w_s2_load) begin
         s1_valid_d = 1'b0;
      end

      w_ovf = s1_diff_q[WIDTH] ^ s1_diff_q[WIDTH-1];
      if (w_s2_load) begin
         s2_valid_d = 1'b1;
         ovf_d      = w_ovf;
         if (SATURATE != 0 && w_ovf) begin
            value_d = s1_diff_q[WIDTH] ? c_max_neg : c_max_pos;
         end else begin
            value_d = s1_diff_q[WIDTH-1:0];
         end
      end else if (w_out_xfer) begin
         s2_valid_d = 1'b0;
      end

      if (w_out_xfer && ovf_q) begin
         sticky_d = 1'b1;
      end else if (CLEAR_STICKY) begin
         sticky_d = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         s1_valid_q <= 1'b0;
         s1_diff_q  <= '0;
         s2_valid_q <= 1'b0;
         value_q    <= '0;
         ovf_q      <= 1'b0;
         sticky_q   <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_diff_q  <= s1_diff_d;
         s2_valid_q <= s2_valid_d;
         value_q    <= value_d;
         ovf_q      <= ovf_d;
         sticky_q   <= sticky_d;
      end
   end

   assign VALUE_OUT       = value_q;
   assign VALID_OUT       = s2_valid_q;
   assign OVERFLOW        = ovf_q;
   assign OVERFLOW_STICKY = sticky_q;

endmodule
`default_nettype wire

// File: tb/tb_fixed_point_sub.sv
`default_nettype none
// ============================================================================
//  tb_fixed_point_sub
//  Scoreboard bench driving a saturating and a wrapping instance in lockstep.
//  Revision: 1.0
// ============================================================================
module tb_fixed_point_sub;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] a, b;
   logic         valid_in, ready_in, clear_sticky;

   logic         ready_out_s, valid_out_s, ovf_s, sticky_s;
   logic [W-1:0] value_s;
   logic         ready_out_w, valid_out_w, ovf_w, sticky_w;
   logic [W-1:0] value_w;

   int           checks   = 0;
   int           failures = 0;
   int           n_out    = 0;
   logic [W:0]   q_sat[$];
   logic [W:0]   q_wrap[$];
   logic [W:0]   exp_s, exp_w;

   always #5 clk = ~clk;

   fixed_point_sub #(.WIDTH(W), .FRAC_BITS(3), .SATURATE(1)) u_sat (
      .CLK(clk), .RST(rst), .VALUE_A_IN(a), .VALUE_B_IN(b), .VALID_IN(valid_in),
      .READY_OUT(ready_out_s), .VALUE_OUT(value_s), .VALID_OUT(valid_out_s),
      .READY_IN(ready_in), .OVERFLOW(ovf_s), .OVERFLOW_STICKY(sticky_s),
      .CLEAR_STICKY(clear_sticky)
   );

   fixed_point_sub #(.WIDTH(W), .FRAC_BITS(3), .SATURATE(0)) u_wrap (
      .CLK(clk), .RST(rst), .VALUE_A_IN(a), .VALUE_B_IN(b), .VALID_IN(valid_in),
      .READY_OUT(ready_out_w), .VALUE_OUT(value_w), .VALID_OUT(valid_out_w),
      .READY_IN(ready_in), .OVERFLOW(ovf_w), .OVERFLOW_STICKY(sticky_w),
      .CLEAR_STICKY(clear_sticky)
   );

   // Reference: {ovf, value} from integer arithmetic.
   function automatic logic [W:0] model(input logic [W-1:0] va, input logic [W-1:0] vb,
                                        input bit sat);
      int          d;
      logic [31:0] dv;
      logic        ovf;
      logic [W-1:0] v;
      d   = int'($signed(va)) - int'($signed(vb));
      dv  = d;
      ovf = (d > 127) || (d < -128);
      v   = dv[W-1:0];
      if (sat && ovf) v = (d > 0) ? 8'h7F : 8'h80;
      return {ovf, v};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (valid_out_s && ready_in) begin
            n_out++;
            if (q_sat.size() == 0 || q_wrap.size() == 0) begin
               chk("spurious_output", {31'b0, valid_out_s}, 32'd0);
            end else begin
               exp_s = q_sat.pop_front();
               exp_w = q_wrap.pop_front();
               chk("sat_value",  value_s,     exp_s[W-1:0]);
               chk("sat_ovf",    ovf_s,       exp_s[W]);
               chk("wrap_valid", valid_out_w, 1);
               chk("wrap_value", value_w,     exp_w[W-1:0]);
               chk("wrap_ovf",   ovf_w,       exp_w[W]);
            end
         end
         if (valid_in && ready_out_s) begin
            q_sat.push_back(model(a, b, 1'b1));
            q_wrap.push_back(model(a, b, 1'b0));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb);
      bit got;
      got      = 1'b0;
      a        = va;
      b        = vb;
      valid_in = 1'b1;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         got = ready_out_s;
         @(posedge clk);
         #1;
      end
      valid_in = 1'b0;
      chk("send_accepted", {31'b0, got}, 1);
   endtask

   task automatic drain(input int max_cycles);
      for (int i = 0; i < max_cycles && q_sat.size() != 0; i++) step();
      chk("drain_empty", q_sat.size(), 0);
   endtask

   initial begin
      logic [W-1:0] ra[10];
      logic [W-1:0] rb[10];
      int           idx;
      int           base;

      rst = 1'b1; a = '0; b = '0; valid_in = 1'b0; ready_in = 1'b1; clear_sticky = 1'b0;
      repeat (3) step();
      chk("rst_valid_out", valid_out_s, 0);
      chk("rst_value_out", value_s,     0);
      chk("rst_overflow",  ovf_s,       0);
      chk("rst_sticky",    sticky_s,    0);
      rst = 1'b0;
      step();
      chk("ready_after_reset", ready_out_s, 1);

      // Basic subtraction and 2-cycle latency.
      send(8'h0C, 8'h12);
      chk("t1_lat_early", valid_out_s, 0);
      step();
      chk("t1_valid",      valid_out_s, 1);
      chk("t1_value",      value_s,     8'hFA);
      step();
      chk("t1_valid_once", valid_out_s, 0);
      chk("t1_sticky",     sticky_s,    0);

      // Positive overflow.
      send(8'h7F, 8'hF8);
      drain(10);
      step();
      chk("t2_sticky_sat",  sticky_s, 1);
      chk("t2_sticky_wrap", sticky_w, 1);

      // Negative overflow, most-negative subtrahend, A == B.
      send(8'h80, 8'h01);
      send(8'h00, 8'h80);
      send(8'h35, 8'h35);
      drain(10);
      step();
      clear_sticky = 1'b1;
      step();
      clear_sticky = 1'b0;
      chk("t3_clear_sat",  sticky_s, 0);
      chk("t3_clear_wrap", sticky_w, 0);

      // Sticky set wins over clear, then clears.
      ready_in = 1'b0;
      send(8'h7F, 8'hF8);
      repeat (2) step();
      chk("t5_held_valid", valid_out_s, 1);
      chk("t5_not_yet",    sticky_s,    0);
      ready_in     = 1'b1;
      clear_sticky = 1'b1;
      step();
      chk("t5_set_wins", sticky_s, 1);
      step();
      clear_sticky = 1'b0;
      chk("t5_cleared", sticky_s, 0);

      // Backpressure stream.
      for (int i = 0; i < 10; i++) begin
         ra[i] = W'($urandom_range(0, 255));
         rb[i] = W'($urandom_range(0, 255));
      end
      ra[5] = 8'h90;
      rb[5] = 8'h40;
      idx  = 0;
      base = n_out;
      for (int cyc = 0; cyc < 60; cyc++) begin
         ready_in = !(cyc >= 3 && cyc <= 6);
         if (idx < 10) begin
            valid_in = 1'b1;
            a        = ra[idx];
            b        = rb[idx];
         end else begin
            valid_in = 1'b0;
         end
         @(negedge clk);
         if (cyc >= 4 && cyc <= 6) begin
            chk("t4_ready_low",  ready_out_s, 0);
            chk("t4_valid_held", valid_out_s, 1);
            chk("t4_value_held", value_s,     q_sat[0][W-1:0]);
         end
         if (valid_in && ready_out_s) idx++;
         @(posedge clk);
         #1;
         if (idx == 10 && q_sat.size() == 0) break;
      end
      valid_in = 1'b0;
      ready_in = 1'b1;
      chk("t4_all_accepted", idx,          10);
      chk("t4_count",        n_out - base, 10);
      chk("t4_queue_empty",  q_sat.size(), 0);

      // Mid-stream reset.
      send(8'h80, 8'h01);
      drain(10);
      step();
      chk("t6_sticky_pre", sticky_s, 1);
      ready_in = 1'b0;
      send(8'h7F, 8'hF8);
      send(8'h01, 8'h02);
      chk("t6_full_valid", valid_out_s, 1);
      chk("t6_full_ready", ready_out_s, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      q_sat.delete();
      q_wrap.delete();
      chk("t6_valid_flushed", valid_out_s, 0);
      chk("t6_sticky_sat",    sticky_s,    0);
      chk("t6_sticky_wrap",   sticky_w,    0);
      chk("t6_ready",         ready_out_s, 1);
      base     = n_out;
      ready_in = 1'b1;
      repeat (6) step();
      chk("t6_no_flushed_out", n_out - base, 0);

      chk("final_queue_sat",  q_sat.size(),  0);
      chk("final_queue_wrap", q_wrap.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
